gnn_io_ctrl: RTL and testbench
==============================

Name: gnn_io_ctrl

Overview:
- Host-side front end for the 4-node GNN accelerator; the other end of the accelerator's parallel load / `in_ready` / `out*_ready` interface.
- Load side: deserialises a 5-bit valid/ready word stream into the 16 feature and 24 weight registers that drive the accelerator, then raises `acc_in_ready`.
- Result side: waits for all eight result-ready flags, captures the eight 21-bit results, then serialises them out on a valid/ready stream with a last marker.
- Watchdog: a timeout counter guards against a hung accelerator.

Parameters:
- IN_W, 5, feature/weight word width (signed)
- OUT_W, 21, result width (signed)
- N_FEAT, 16, feature words per job (4 nodes x 4 features)
- N_WGT, 24, weight words per job
- N_RES, 8, results per job (2 per node)
- TIMEOUT, 64, max WAIT cycles before abort (>=8)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_data  in  IN_W  load word
- s_valid  in  1  load word valid
- s_ready  out  1  load word accepted when s_valid&s_ready
- acc_x  out  N_FEAT*IN_W  features; slice k = word k
- acc_w  out  N_WGT*IN_W  weights; slice k = word N_FEAT+k
- acc_in_ready  out  1  job start level to accelerator
- acc_res  in  N_RES*OUT_W  results; slice r
- acc_res_rdy  in  N_RES  per-result ready flags
- m_data  out  OUT_W  result word
- m_valid  out  1  result valid
- m_ready  in  1  result sink ready
- m_last  out  1  marks final result of job
- busy  out  1  high in any state except LOAD with word index 0
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
- On reset:
  - state LOAD, word index and result index 0, timeout counter 0, armed 0.
  - acc_x, acc_w and the result buffer all 0.
  - acc_in_ready 0, m_valid 0, m_last 0, timeout_err 0, s_ready 1, busy 0.
- Reset mid-job: the job is discarded with no partial output.
- Word order:
  - 0..15 = node0 x0..x3, node1 x0..x3, node2 x0..x3, node3 x0..x3.
  - 16..39 = w04,w14,w24,w34, w05..w35, w06..w36, w07..w37, w48,w58,w68,w78, w49,w59,w69,w79.
- Result order: r0..r7 = out0_node0, out1_node0, out0_node1, ..., out1_node3.
- FSM LOAD:
  - s_ready=1.
  - Each accepted word writes slice[idx] and increments idx; gaps in s_valid are allowed.
  - The first accepted word clears timeout_err.
  - Accepting idx=39 moves to WAIT next cycle with idx=0.
- Register stability: acc_x/acc_w are written only in LOAD, so they are stable through WAIT.
- FSM WAIT:
  - acc_in_ready=1, s_ready=0, timeout counter increments each cycle.
  - armed is set on any cycle with acc_res_rdy != all-ones, so stale flags from the previous job are ignored.
  - When armed & all flags high: capture all eight results in that cycle, clear acc_in_ready, go to DRAIN.
  - Capture has priority over timeout in the same cycle.
  - When counter reaches TIMEOUT-1 without capture: set timeout_err, clear acc_in_ready, discard the job, go to LOAD.
- FSM DRAIN:
  - acc_in_ready=0, which guarantees at least one low cycle before the next rising edge.
  - m_valid=1, m_data=buf[ridx], m_last=(ridx==7).
  - ridx advances on m_valid&m_ready.
  - Transfer with m_last moves to LOAD.
  - m_data must hold stable while m_valid&~m_ready.
- Arithmetic: pure data movement; no sign changes or truncation; results are stored at full OUT_W.
- Minimum job length: 40 load cycles + 1 WAIT entry + accelerator latency + 8 drain cycles.

Decomposition:
- Package gnn_io_pkg:
  - gnn_io_state_t enum {LOAD, WAIT, DRAIN}.
  - Localparams N_FEAT, N_WGT, N_WORDS=40, N_RES, IN_W, OUT_W.
  - Word-order constants.
- Sub-module gnn_io_deser: stream-to-register-file loader with index counter and done pulse.
  - The top holds the FSM, watchdog and result buffer/serialiser.

Test Plan:
- Happy path: stream 40 words (features 1..16 mod range, weights all 1); a behavioural accelerator raises flags 5 cycles after the in_ready rise with results 100..107.
  - Expect acc_in_ready high the cycle after word 39.
  - Expect acc_x slice 0=1.
  - Expect m_data sequence 100..107, m_last only on 107, then s_ready=1.
- Backpressure: toggle m_ready 0/1 every cycle during DRAIN.
  - Expect exactly 8 transfers, m_data stable while stalled, order unchanged.
- Stale flags: hold acc_res_rdy=8'hFF when WAIT is entered, drop it for 1 cycle, then raise it with results 200..207.
  - Expect results 200..207, not the earlier stale values.
- Timeout: flags never rise.
  - Expect timeout_err=1 and acc_in_ready=0 after 64 WAIT cycles, no m_valid, state LOAD.
  - Expect timeout_err cleared on the next accepted word.
- Gapped load: s_valid random 50% duty.
  - Expect acc_w slice 23 = word 39 and no early acc_in_ready.
- Reset mid-WAIT: assert rst_n low for 1 cycle.
  - Expect acc_in_ready=0, busy=0, acc_x=0 immediately, and no output words.

Source files
------------

// File: rtl/gnn_io_pkg.sv
// Shared widths, job geometry and FSM encoding for the GNN accelerator host front end.
package gnn_io_pkg;

    localparam int IN_W        = 5;
    localparam int OUT_W       = 21;
    localparam int N_FEAT      = 16;
    localparam int N_WGT       = 24;
    localparam int N_WORDS     = N_FEAT + N_WGT;
    localparam int N_RES       = 8;
    localparam int TIMEOUT_DEF = 64;

    // Load words 0..15 are features (node-major), 16..39 are weights.
    localparam int WGT_BASE  = N_FEAT;
    localparam int LAST_WORD = N_WORDS - 1;
    localparam int LAST_RES  = N_RES - 1;

    localparam int IDX_W  = $clog2(N_WORDS);
    localparam int RIDX_W = $clog2(N_RES);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } gnn_io_state_t;

endpackage

// File: rtl/gnn_io_if.sv
// Host-facing streams: load words in (s_*) and result words out (m_*).
interface gnn_io_if;

    logic [gnn_io_pkg::IN_W-1:0]  s_data;
    logic                         s_valid;
    logic                         s_ready;
    logic [gnn_io_pkg::OUT_W-1:0] m_data;
    logic                         m_valid;
    logic                         m_ready;
    logic                         m_last;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

endinterface

// File: rtl/gnn_io_deser.sv
// Load-word deserialiser: writes each accepted word into the next register slot
// and pulses done on the final word, wrapping the index back to 0.
module gnn_io_deser
    import gnn_io_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IN_W-1:0]          wr_data,
    output logic [N_WORDS*IN_W-1:0]  words,
    output logic [IDX_W-1:0]         idx,
    output logic                     done
);

    logic [IN_W-1:0]  word_reg [N_WORDS];
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic [N_WORDS-1:0] word_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi++) begin : g_word
            assign word_sel[gi]               = wr_en && (idx_reg == IDX_W'(gi));
            assign words[gi*IN_W +: IN_W]     = word_reg[gi];
        end
    endgenerate

    assign done = wr_en && (idx_reg == IDX_W'(LAST_WORD));
    assign idx  = idx_reg;

    always_comb begin
        idx_next = idx_reg;
        if (done) begin
            idx_next = '0;
        end else if (wr_en) begin
            idx_next = idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                word_reg[i] <= '0;
            end
        end else begin
            idx_reg <= idx_next;
            for (int i = 0; i < N_WORDS; i++) begin
                if (word_sel[i]) begin
                    word_reg[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/gnn_io_ctrl.sv
// Host front end for the 4-node GNN accelerator: loads a job, waits for fresh
// results under a watchdog, then streams the eight results out.
module gnn_io_ctrl
    import gnn_io_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gnn_io_if.slave                  io,
    output logic [N_FEAT*IN_W-1:0]   acc_x,
    output logic [N_WGT*IN_W-1:0]    acc_w,
    output logic                     acc_in_ready,
    input  logic [N_RES*OUT_W-1:0]   acc_res,
    input  logic [N_RES-1:0]         acc_res_rdy,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int TCNT_W = $clog2(TIMEOUT);

    gnn_io_state_t     state_reg, state_next;
    logic [RIDX_W-1:0] ridx_reg, ridx_next;
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic              armed_reg, armed_next;
    logic              terr_reg, terr_next;
    logic              capture;

    logic [OUT_W-1:0]  res_in  [N_RES];
    logic [OUT_W-1:0]  res_buf_reg [N_RES];

    logic [N_WORDS*IN_W-1:0] load_words;
    logic [IDX_W-1:0]        load_idx;
    logic                    load_done;
    logic                    accept;
    logic                    all_rdy;

    assign accept  = io.s_valid && io.s_ready;
    assign all_rdy = (acc_res_rdy == {N_RES{1'b1}});

    gnn_io_deser u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (io.s_data),
        .words   (load_words),
        .idx     (load_idx),
        .done    (load_done)
    );

    assign acc_x = load_words[N_FEAT*IN_W-1:0];
    assign acc_w = load_words[N_WORDS*IN_W-1:WGT_BASE*IN_W];

    genvar gi;
    generate
        for (gi = 0; gi < N_RES; gi++) begin : g_res
            assign res_in[gi] = acc_res[gi*OUT_W +: OUT_W];
        end
    endgenerate

    // Flags that were already all-high on WAIT entry belong to the previous job;
    // only a capture after at least one not-all-high cycle is accepted.
    always_comb begin
        state_next = state_reg;
        ridx_next  = ridx_reg;
        tcnt_next  = tcnt_reg;
        armed_next = armed_reg;
        terr_next  = terr_reg;
        capture    = 1'b0;
        case (state_reg)
            LOAD: begin
                if (accept && (load_idx == '0)) begin
                    terr_next = 1'b0;
                end
                if (load_done) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                tcnt_next = tcnt_reg + TCNT_W'(1);
                if (!all_rdy) begin
                    armed_next = 1'b1;
                end
                if (armed_reg && all_rdy) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                    tcnt_next  = '0;
                    armed_next = 1'b0;
                end else if (tcnt_reg == TCNT_W'(TIMEOUT - 1)) begin
                    terr_next  = 1'b1;
                    state_next = LOAD;
                    tcnt_next  = '0;
                    armed_next = 1'b0;
                end
            end
            DRAIN: begin
                if (io.m_ready) begin
                    if (ridx_reg == RIDX_W'(LAST_RES)) begin
                        ridx_next  = '0;
                        state_next = LOAD;
                    end else begin
                        ridx_next = ridx_reg + RIDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD;
            ridx_reg  <= '0;
            tcnt_reg  <= '0;
            armed_reg <= 1'b0;
            terr_reg  <= 1'b0;
            for (int i = 0; i < N_RES; i++) begin
                res_buf_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            ridx_reg  <= ridx_next;
            tcnt_reg  <= tcnt_next;
            armed_reg <= armed_next;
            terr_reg  <= terr_next;
            if (capture) begin
                for (int i = 0; i < N_RES; i++) begin
                    res_buf_reg[i] <= res_in[i];
                end
            end
        end
    end

    // Output stage decodes straight from registered state, so m_data only
    // moves on a completed transfer.
    assign io.s_ready   = (state_reg == LOAD);
    assign io.m_valid   = (state_reg == DRAIN);
    assign io.m_data    = res_buf_reg[ridx_reg];
    assign io.m_last    = (state_reg == DRAIN) && (ridx_reg == RIDX_W'(LAST_RES));
    assign acc_in_ready = (state_reg == WAIT);
    assign busy         = !((state_reg == LOAD) && (load_idx == '0));
    assign timeout_err  = terr_reg;

endmodule

// File: tb/tb_gnn_io_ctrl.sv
// Self-checking bench for gnn_io_ctrl: a table of job scenarios plus randomized
// jobs, with a behavioural accelerator and result scoreboard in the bench.
module tb_gnn_io_ctrl;
    import gnn_io_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_FEAT*IN_W-1:0]  acc_x;
    logic [N_WGT*IN_W-1:0]   acc_w;
    logic                    acc_in_ready;
    logic [N_RES*OUT_W-1:0]  acc_res;
    logic [N_RES-1:0]        acc_res_rdy;
    logic                    busy;
    logic                    timeout_err;

    gnn_io_if io ();

    gnn_io_ctrl #(.TIMEOUT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io           (io),
        .acc_x        (acc_x),
        .acc_w        (acc_w),
        .acc_in_ready (acc_in_ready),
        .acc_res      (acc_res),
        .acc_res_rdy  (acc_res_rdy),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int feat_mode;   // 0: (k+1) wrapped to 5 bits, 1: random
        int wgt_mode;    // 0: all ones, 1: random
        int gap_pct;     // chance of an idle cycle before each word
        int res_base;    // results base+r, or random when negative
        int latency;     // WAIT cycle on which flags rise
        int bp_mode;     // 0: m_ready high, 1: toggle, 2: random
        bit stale;       // flags already high on WAIT entry
        bit expect_to;   // accelerator never answers
        int reset_at;    // WAIT cycle to pulse reset, negative for none
    } job_vec_t;

    int checks   = 0;
    int failures = 0;
    bit model_terr = 1'b0;
    logic [IN_W-1:0]  words [N_WORDS];
    logic [OUT_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input int id, input job_vec_t v);
        logic [N_FEAT*IN_W-1:0] exp_x;
        logic [N_WGT*IN_W-1:0]  exp_w;
        logic [OUT_W-1:0]       val;
        logic [OUT_W-1:0]       prev_data;
        int early, cnt, mv_seen, n, cyc, unstable;
        bit mr, prev_stall;

        for (int k = 0; k < N_WORDS; k++) begin
            if (k < N_FEAT) words[k] = (v.feat_mode == 0) ? IN_W'(k + 1) : IN_W'($urandom);
            else            words[k] = (v.wgt_mode == 0) ? IN_W'(1) : IN_W'($urandom);
        end
        for (int k = 0; k < N_FEAT; k++) exp_x[k*IN_W +: IN_W] = words[k];
        for (int k = 0; k < N_WGT; k++)  exp_w[k*IN_W +: IN_W] = words[N_FEAT + k];

        if (v.stale) begin
            for (int r = 0; r < N_RES; r++) acc_res[r*OUT_W +: OUT_W] = OUT_W'(500 + r);
            acc_res_rdy = '1;
        end else begin
            acc_res_rdy = '0;
        end

        early = 0;
        for (int k = 0; k < N_WORDS; k++) begin
            while (v.gap_pct > 0 && $urandom_range(99, 0) < v.gap_pct) begin
                io.s_valid = 1'b0;
                @(negedge clk);
                if (acc_in_ready) early++;
            end
            if (k == 0) begin
                check("busy_idle", busy, 0);
                check("terr_before_load", timeout_err, model_terr);
            end
            io.s_valid = 1'b1;
            io.s_data  = words[k];
            @(negedge clk);
            if (k == 0) begin
                model_terr = 1'b0;
                check("terr_after_first_word", timeout_err, 0);
                check("busy_loading", busy, 1);
            end
            if (k < N_WORDS - 1 && acc_in_ready) early++;
        end
        io.s_valid = 1'b0;

        check("no_early_in_ready", early, 0);
        check("in_ready_rise", acc_in_ready, 1);
        check("s_ready_wait", io.s_ready, 0);
        check("acc_x", acc_x, exp_x);
        check("acc_w", acc_w, exp_w);
        check("acc_x_slice0", acc_x[IN_W-1:0], words[0]);
        check("acc_w_slice23", acc_w[23*IN_W +: IN_W], words[N_WORDS-1]);

        if (v.reset_at >= 0) begin
            for (int c = 0; c < v.reset_at; c++) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("rst_in_ready", acc_in_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_acc_x", acc_x, 0);
            check("rst_acc_w", acc_w, 0);
            check("rst_s_ready", io.s_ready, 1);
            @(negedge clk);
            rst_n = 1'b1;
            io.m_ready = 1'b1;
            mv_seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (c == 1) acc_res_rdy = '1;
                if (io.m_valid || acc_in_ready) mv_seen++;
            end
            check("no_output_after_reset", mv_seen, 0);
            acc_res_rdy = '0;
            io.m_ready  = 1'b0;
            model_terr  = 1'b0;
            $display("job %0d reset mid-wait done", id);
            return;
        end

        if (v.expect_to) begin
            cnt = 0;
            mv_seen = 0;
            while (acc_in_ready && cnt < 200) begin
                if (io.m_valid) mv_seen++;
                cnt++;
                @(negedge clk);
            end
            model_terr = 1'b1;
            check("timeout_wait_cycles", cnt, 64);
            check("timeout_err_set", timeout_err, 1);
            check("timeout_in_ready_low", acc_in_ready, 0);
            check("timeout_no_m_valid", mv_seen + int'(io.m_valid), 0);
            check("timeout_back_to_load", io.s_ready, 1);
            check("timeout_busy_low", busy, 0);
            $display("job %0d timeout after %0d wait cycles", id, cnt);
            return;
        end

        if (v.stale) begin
            @(negedge clk);
            check("stale_flags_ignored", acc_in_ready, 1);
            acc_res_rdy = '0;
            @(negedge clk);
            check("stale_still_waiting", acc_in_ready, 1);
        end else begin
            for (int c = 0; c < v.latency; c++) @(negedge clk);
            check("wait_held", acc_in_ready, 1);
        end
        for (int r = 0; r < N_RES; r++) begin
            val = (v.res_base < 0) ? OUT_W'($urandom) : OUT_W'(v.res_base + r);
            acc_res[r*OUT_W +: OUT_W] = val;
            exp_q.push_back(val);
        end
        acc_res_rdy = '1;
        @(negedge clk);
        check("capture_in_ready_low", acc_in_ready, 0);
        check("capture_m_valid", io.m_valid, 1);
        acc_res     = ~acc_res;
        acc_res_rdy = '0;

        n = 0;
        cyc = 0;
        unstable = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while (n < N_RES && cyc < 100) begin
            if (prev_stall && io.m_data !== prev_data) unstable++;
            case (v.bp_mode)
                0:       mr = 1'b1;
                1:       mr = cyc[0];
                default: mr = 1'($urandom_range(1, 0));
            endcase
            io.m_ready = mr;
            if (io.m_valid && mr) begin
                val = exp_q.pop_front();
                $display("job %0d xfer %0d data=%0h last=%0d", id, n, io.m_data, io.m_last);
                check("m_data", io.m_data, val);
                check("m_last", io.m_last, (n == N_RES - 1));
                n++;
            end
            prev_stall = io.m_valid && !mr;
            prev_data  = io.m_data;
            @(negedge clk);
            cyc++;
        end
        io.m_ready = 1'b0;
        check("drain_count", n, N_RES);
        check("drain_data_stable", unstable, 0);
        check("drain_done_m_valid", io.m_valid, 0);
        check("drain_done_s_ready", io.s_ready, 1);
        check("drain_done_busy", busy, 0);
        exp_q.delete();
    endtask

    job_vec_t table_v [7];
    job_vec_t rv;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        //          feat wgt gap  base lat bp stale to reset
        table_v[0] = '{0, 0,  0, 100,  5, 0, 0, 0, -1};  // happy path
        table_v[1] = '{1, 1,  0, 300,  3, 1, 0, 0, -1};  // backpressure
        table_v[2] = '{0, 1,  0, 200,  0, 0, 1, 0, -1};  // stale flags
        table_v[3] = '{1, 1,  0,   0,  0, 0, 0, 1, -1};  // timeout
        table_v[4] = '{1, 1, 50, 400, 10, 2, 0, 0, -1};  // gapped load, clears error
        table_v[5] = '{1, 0,  0, 600, 63, 0, 0, 0, -1};  // capture beats timeout
        table_v[6] = '{1, 1, 20,   0,  0, 0, 0, 0,  3};  // reset mid-wait

        rst_n       = 1'b0;
        io.s_valid  = 1'b0;
        io.s_data   = '0;
        io.m_ready  = 1'b0;
        acc_res     = '0;
        acc_res_rdy = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_in_ready", acc_in_ready, 0);
        check("reset_m_valid", io.m_valid, 0);
        check("reset_m_last", io.m_last, 0);
        check("reset_timeout_err", timeout_err, 0);
        check("reset_s_ready", io.s_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_acc_x", acc_x, 0);
        check("reset_acc_w", acc_w, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_s_ready", io.s_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_job(i, table_v[i]);
            $display("job %0d done checks=%0d", i, checks);
        end

        for (int i = 0; i < 6; i++) begin
            rv = '{1, 1, int'($urandom_range(60, 0)), -1, int'($urandom_range(40, 1)),
                   2, 0, 0, -1};
            run_job(100 + i, rv);
            $display("job %0d done checks=%0d", 100 + i, checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
